// File: rtl/pe_cmd_issuer.sv
// Initiator side of a message_passer PE's ack/ready command handshake.
// Queues host commands, issues them one at a time, returns captured PE state as a result beat.
module pe_cmd_issuer #(
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int command_width    = 4,
  parameter int DEPTH            = 8,
  parameter int TIMEOUT          = 255
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [command_width-1:0]    in_cmd,
  input  logic [OUTPUT_PRECISION-1:0] in_data,
  input  logic                        pe_ready,
  output logic                        pe_ack,
  output logic [command_width-1:0]    command_to_execute,
  output logic [PRECISION-1:0]        a_overwrite,
  output logic [PRECISION-1:0]        b_overwrite,
  output logic [OUTPUT_PRECISION-1:0] s_out_overwrite,
  input  logic [PRECISION-1:0]        pe_A,
  input  logic [PRECISION-1:0]        pe_B,
  input  logic [OUTPUT_PRECISION-1:0] pe_s_out,
  output logic                        res_valid,
  output logic [command_width-1:0]    res_cmd,
  output logic [PRECISION-1:0]        res_A,
  output logic [PRECISION-1:0]        res_B,
  output logic [OUTPUT_PRECISION-1:0] res_s_out,
  output logic                        busy,
  output logic                        timeout_err,
  input  logic                        clr_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [command_width-1:0] CMD_WR_A = command_width'(5);
  localparam logic [command_width-1:0] CMD_WR_B = command_width'(6);
  localparam logic [command_width-1:0] CMD_WR_S = command_width'(7);

  typedef enum logic [1:0] {IDLE, ACK, ISSUE, DONE} state_t;
  state_t state;

  logic [command_width-1:0]    cmd_mem  [DEPTH];
  logic [OUTPUT_PRECISION-1:0] data_mem [DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr, head_ptr;
  logic [AW:0]                 count;
  logic [WW-1:0]               wd_cnt;
  logic                        full, empty, push, pop, avail_q, wd_fire, launch;
  logic [command_width-1:0]    head_cmd;
  logic [OUTPUT_PRECISION-1:0] head_data;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = (state != IDLE) || !empty;

  // Watchdog fires only when the phase would otherwise keep waiting.
  assign wd_fire  = ((state == ACK && pe_ready) || (state == ISSUE && !pe_ready)) &&
                    (wd_cnt == WW'(TIMEOUT - 1));
  assign pop      = (state == DONE) || wd_fire;

  // In DONE the current head is being popped, so the next entry sits one slot ahead.
  // IDLE waits a cycle on avail_q so a fresh push is never read in its write cycle.
  assign head_ptr  = (state == DONE) ? rd_ptr + AW'(1) : rd_ptr;
  assign head_cmd  = cmd_mem[head_ptr];
  assign head_data = data_mem[head_ptr];
  assign launch    = (state == IDLE && avail_q && !empty) ||
                     (state == DONE && count > (AW+1)'(1));

  always_ff @(posedge CLK) begin
    if (push) begin
      cmd_mem[wr_ptr]  <= in_cmd;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      avail_q            <= 1'b0;
      wd_cnt             <= '0;
      pe_ack             <= 1'b0;
      command_to_execute <= '0;
      a_overwrite        <= '0;
      b_overwrite        <= '0;
      s_out_overwrite    <= '0;
      res_valid          <= 1'b0;
      res_cmd            <= '0;
      res_A              <= '0;
      res_B              <= '0;
      res_s_out          <= '0;
      timeout_err        <= 1'b0;
    end else begin
      avail_q   <= !empty;
      res_valid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);

      if (wd_fire)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;

      if (launch) begin
        command_to_execute <= head_cmd;
        case (head_cmd)
          CMD_WR_A: a_overwrite     <= head_data[PRECISION-1:0];
          CMD_WR_B: b_overwrite     <= head_data[PRECISION-1:0];
          CMD_WR_S: s_out_overwrite <= head_data;
          default: ;
        endcase
      end

      case (state)
        IDLE: if (launch) begin
          state  <= ACK;
          pe_ack <= 1'b1;
          wd_cnt <= '0;
        end
        ACK: begin
          if (!pe_ready) begin
            state  <= ISSUE;
            pe_ack <= 1'b0;
            wd_cnt <= '0;
          end else if (wd_fire) begin
            state  <= IDLE;
            pe_ack <= 1'b0;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        ISSUE: begin
          if (pe_ready) begin
            state     <= DONE;
            wd_cnt    <= '0;
            res_valid <= 1'b1;
            res_cmd   <= command_to_execute;
            res_A     <= pe_A;
            res_B     <= pe_B;
            res_s_out <= pe_s_out;
          end else if (wd_fire) begin
            state  <= IDLE;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        DONE: begin
          wd_cnt <= '0;
          if (launch) begin
            state  <= ACK;
            pe_ack <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_cmd_issuer.sv
// Bench for pe_cmd_issuer: behavioural PE model plus an in-order result reference.
module tb_pe_cmd_issuer;
  localparam int P = 8, OP = 32, CW = 4, D = 8, TO = 20;

  logic          CLK = 1'b0, RST = 1'b1, in_valid = 1'b0, pe_ready = 1'b1, clr_err = 1'b0;
  logic [CW-1:0] in_cmd = '0;
  logic [OP-1:0] in_data = '0;
  logic          in_ready, pe_ack, res_valid, busy, timeout_err;
  logic [CW-1:0] command_to_execute, res_cmd;
  logic [P-1:0]  a_overwrite, b_overwrite, res_A, res_B;
  logic [OP-1:0] s_out_overwrite, res_s_out;
  logic [P-1:0]  pA = '0, pB = '0;
  logic [OP-1:0] pS = '0;

  typedef struct { logic [CW-1:0] cmd; logic [OP-1:0] data; } ent_t;
  ent_t          q[$];
  logic [OP-1:0] s_hist[$];
  logic [P-1:0]  rA = '0, rB = '0;
  logic [OP-1:0] rS = '0;
  int            n_chk = 0, n_bad = 0, n_res = 0;
  int            drop_dly = 0, rise_dly = 1;
  bit            pe_hang = 1'b0;
  logic          prev_rv = 1'b0;

  pe_cmd_issuer #(.PRECISION(P), .OUTPUT_PRECISION(OP), .command_width(CW),
                  .DEPTH(D), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_data(in_data), .pe_ready(pe_ready), .pe_ack(pe_ack),
    .command_to_execute(command_to_execute), .a_overwrite(a_overwrite),
    .b_overwrite(b_overwrite), .s_out_overwrite(s_out_overwrite),
    .pe_A(pA), .pe_B(pB), .pe_s_out(pS), .res_valid(res_valid),
    .res_cmd(res_cmd), .res_A(res_A), .res_B(res_B), .res_s_out(res_s_out),
    .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Called in the post-edge phase; the entry is offered across exactly one edge.
  task automatic push(input logic [CW-1:0] c, input logic [OP-1:0] d, input logic exp_rdy);
    ent_t e;
    in_valid = 1'b1; in_cmd = c; in_data = d;
    chk("in_ready", in_ready, exp_rdy);
    if (exp_rdy) begin e.cmd = c; e.data = d; q.push_back(e); end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy || q.size() != 0) && n < budget) begin tick(); n++; end
    chk("drain_in_time", n < budget, 1);
    chk("fifo_drained", q.size(), 0);
  endtask

  task automatic wait_ack(output int n);
    int w = 0;
    while (!pe_ack && w < 20) begin tick(); w++; end
    chk("ack_seen", pe_ack, 1);
    n = 0;
    while (pe_ack && n < 3 * TO) begin tick(); n++; end
  endtask

  // PE: drops ready drop_dly cycles after seeing ack, executes, raises ready rise_dly later.
  initial begin
    forever begin
      tick();
      if (pe_ack && !pe_hang) begin
        repeat (drop_dly) tick();
        pe_ready = 1'b0;
        case (command_to_execute)
          4'd0: pS = pS + OP'(pA) * OP'(pB);
          4'd5: pA = a_overwrite;
          4'd6: pB = b_overwrite;
          4'd7: pS = s_out_overwrite;
          4'd8: begin pA = '0; pB = '0; pS = '0; end
          default: ;
        endcase
        repeat (rise_dly) tick();
        pe_ready = 1'b1;
      end
    end
  end

  // Reference: each host entry, applied in push order, defines the next expected result.
  always @(negedge CLK) begin
    if (res_valid) begin : mon
      ent_t e;
      n_res++;
      s_hist.push_back(res_s_out);
      chk("res_one_cycle", prev_rv, 0);
      chk("res_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        case (e.cmd)
          4'd0: rS = rS + OP'(rA) * OP'(rB);
          4'd5: rA = e.data[P-1:0];
          4'd6: rB = e.data[P-1:0];
          4'd7: rS = e.data;
          4'd8: begin rA = '0; rB = '0; rS = '0; end
          default: ;
        endcase
        chk("res_cmd", res_cmd, e.cmd);
        chk("res_A", res_A, rA);
        chk("res_B", res_B, rB);
        chk("res_s_out", res_s_out, rS);
      end
    end
    prev_rv = res_valid;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, n, r0;
    #2;
    chk("rst_pe_ack", pe_ack, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", command_to_execute, 0);
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_timeout_err", timeout_err, 0);

    // Minimum latency: ready drops and rises in consecutive cycles.
    drop_dly = 0; rise_dly = 1;
    push(4'd0, $urandom, 1);
    lat = 0;
    while (!res_valid && lat < 50) begin tick(); lat++; end
    chk("push_to_res_latency", lat, 4);
    drain(100);

    // Shift: ack must stay up until ready is seen low.
    drop_dly = 2; rise_dly = 3;
    push(4'd1, $urandom, 1);
    begin
      int w = 0;
      while (!pe_ack && w < 20) begin tick(); w++; end
    end
    n = 0;
    while (pe_ack && n < 100) begin
      chk("shift_cmd_stable", command_to_execute, 4'd1);
      tick(); n++;
    end
    chk("shift_ack_cycles", n, drop_dly + 1);
    drain(100);
    chk("shift_cmd_held", command_to_execute, 4'd1);
    chk("shift_res_cmd", res_cmd, 4'd1);

    // MAC chain
    drop_dly = 1; rise_dly = 1;
    push(4'd5, 32'h3D, 1);
    push(4'd6, 32'h71, 1);
    push(4'd0, $urandom, 1);
    push(4'd0, $urandom, 1);
    drain(200);
    chk("mac_a_overwrite", a_overwrite, 8'h3D);
    chk("mac_b_overwrite", b_overwrite, 8'h71);
    chk("mac_s_first", s_hist[s_hist.size()-2], 6893);
    chk("mac_s_second", s_hist[s_hist.size()-1], 13786);

    // Full FIFO: slow PE holds the head while DEPTH+1 pushes arrive.
    drop_dly = 12; rise_dly = 1;
    r0 = n_res;
    for (int i = 0; i <= D; i++) push(CW'(i % 5), $urandom, i < D);
    drain(1000);
    chk("full_result_count", n_res - r0, D);
    chk("full_no_timeout", timeout_err, 0);

    // Timeout: PE never drops ready.
    pe_hang = 1'b1; drop_dly = 1; rise_dly = 1;
    r0 = n_res;
    push(4'd0, $urandom, 1);
    push(4'd5, 32'hA7, 1);
    wait_ack(n);
    chk("wd_ack_cycles", n, TO);
    chk("wd_timeout_err", timeout_err, 1);
    chk("wd_no_result", n_res, r0);
    q.delete(0);
    pe_hang = 1'b0;
    drain(200);
    chk("wd_next_issued", n_res - r0, 1);
    chk("wd_err_sticky", timeout_err, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("wd_clr_err", timeout_err, 0);

    // Reset while waiting in ISSUE.
    drop_dly = 0; rise_dly = 10;
    push(4'd7, 32'hCAFE_1234, 1);
    wait_ack(n);
    chk("issue_ready_low", pe_ready, 0);
    #2; RST = 1'b1; #1;
    chk("mid_rst_pe_ack", pe_ack, 0);
    chk("mid_rst_cmd", command_to_execute, 0);
    chk("mid_rst_overwrites", {a_overwrite, b_overwrite, s_out_overwrite}, 0);
    chk("mid_rst_res", {res_valid, res_cmd, res_A, res_B, res_s_out}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    r0 = n_res;
    tick(); tick();
    RST = 1'b0;
    repeat (15) tick();
    chk("post_rst_no_res", n_res, r0);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_ack_low", pe_ack, 0);
    // Resynchronise PE model and reference state.
    drop_dly = 0; rise_dly = 1;
    push(4'd8, '0, 1);
    drain(100);

    // Randomized traffic
    r0 = n_res;
    for (int i = 0; i < 40; i++) begin
      int g = 0;
      while (q.size() >= D - 1 && g < 200) begin tick(); g++; end
      drop_dly = $urandom_range(0, 3);
      rise_dly = $urandom_range(1, 3);
      push(CW'($urandom_range(0, 15)), $urandom, 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain(1000);
    chk("rand_result_count", n_res - r0, 40);
    chk("rand_no_timeout", timeout_err, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
